// File: rtl/snapshot_serializer.sv
// ---------------------------------------------------------------------------
// snapshot_serializer
//
// Freezes CANT_CANALES debug words in one clock edge on i_start. The enabled
// channels are then streamed to the UART transmitter, one byte at a time and
// MSB first, over the tx_start/tx_done handshake. Channels are visited in
// ascending index order.
//
// Optional feature: define SNAPSHOT_SERIALIZER_CHECKSUM_EN to append one
// trailing byte to every frame. That byte is the XOR of all data bytes sent in
// the frame; an all-zero mask then sends the single byte 0x00.
//
// Ports:
//   i_clock     clock, rising edge
//   i_reset     synchronous active-high reset
//   i_canales   flattened channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_mask      channel enable, sampled together with i_start
//   i_start     capture-and-send request, honoured only when idle
//   i_tx_done   one-cycle pulse from tx: previous byte finished
//   o_tx_start  one-cycle pulse, o_data_tx valid in the same cycle
//   o_data_tx   byte to transmit
//   o_busy      frame in progress
//   o_done      one-cycle pulse when the frame has completed
// ---------------------------------------------------------------------------
module snapshot_serializer #(
    parameter int unsigned CANT_CANALES       = 4,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned OUTPUT_WORD_LENGTH = 8
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic [CANT_CANALES*DATA_WIDTH-1:0] i_canales,
    input  logic [CANT_CANALES-1:0]            i_mask,
    input  logic                               i_start,
    input  logic                               i_tx_done,
    output logic                               o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0]      o_data_tx,
    output logic                               o_busy,
    output logic                               o_done
);

    localparam int unsigned BPC  = DATA_WIDTH / OUTPUT_WORD_LENGTH;
    localparam int unsigned CH_W = (CANT_CANALES > 1) ? $clog2(CANT_CANALES) : 1;
    localparam int unsigned BW   = (BPC > 1) ? $clog2(BPC) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_NEXT,
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   snap_q [CANT_CANALES];
    logic [CANT_CANALES-1:0] mask_q;
    logic [CH_W-1:0]         ch_idx_q;
    logic [BW-1:0]           byte_idx_q;
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
    logic [OUTPUT_WORD_LENGTH-1:0] csum_q;
    logic                          chk_q;   // set once the checksum byte is the one in flight
`endif

    logic [DATA_WIDTH-1:0]         cur_word_d;
    logic [OUTPUT_WORD_LENGTH-1:0] cur_byte_d;
    logic [CH_W:0]                 first_hit_d;   // {found, index}
    logic [CH_W:0]                 next_hit_d;    // {found, index}

    // Lowest set bit of m strictly above 'from' (or at 'from' when incl=1).
    function automatic logic [CH_W:0] find_set(input logic [CANT_CANALES-1:0] m,
                                               input logic [CH_W-1:0]         from,
                                               input logic                    incl);
        logic            found;
        logic [CH_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < CANT_CANALES; k++) begin
            if (!found && m[k] &&
                ((CH_W'(k) > from) || (incl && (CH_W'(k) == from)))) begin
                found = 1'b1;
                idx   = CH_W'(k);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        cur_word_d = '0;
        for (int unsigned k = 0; k < CANT_CANALES; k++) begin
            if (CH_W'(k) == ch_idx_q) cur_word_d = snap_q[k];
        end
        // Byte 0 is the most significant byte of the word.
        cur_byte_d = '0;
        for (int unsigned b = 0; b < BPC; b++) begin
            if (BW'(b) == byte_idx_q)
                cur_byte_d = cur_word_d[DATA_WIDTH-1-b*OUTPUT_WORD_LENGTH -: OUTPUT_WORD_LENGTH];
        end
        first_hit_d = find_set(i_mask, '0, 1'b1);
        next_hit_d  = find_set(mask_q, ch_idx_q, 1'b0);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            for (int unsigned k = 0; k < CANT_CANALES; k++) snap_q[k] <= '0;
            mask_q     <= '0;
            ch_idx_q   <= '0;
            byte_idx_q <= '0;
            o_tx_start <= 1'b0;
            o_data_tx  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
            csum_q     <= '0;
            chk_q      <= 1'b0;
`endif
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        for (int unsigned k = 0; k < CANT_CANALES; k++)
                            snap_q[k] <= i_canales[k*DATA_WIDTH +: DATA_WIDTH];
                        mask_q     <= i_mask;
                        ch_idx_q   <= first_hit_d[CH_W-1:0];
                        byte_idx_q <= '0;
                        o_busy     <= 1'b1;
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
                        csum_q     <= '0;
                        chk_q      <= 1'b0;
                        state_q    <= first_hit_d[CH_W] ? S_SEND : S_CHK;
`else
                        state_q    <= first_hit_d[CH_W] ? S_SEND : S_DONE;
`endif
                    end
                end
                S_SEND: begin
                    o_tx_start <= 1'b1;
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
                    if (chk_q) begin
                        o_data_tx <= csum_q;
                    end else begin
                        o_data_tx <= cur_byte_d;
                        csum_q    <= csum_q ^ cur_byte_d;
                    end
`else
                    o_data_tx  <= cur_byte_d;
`endif
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) state_q <= S_NEXT;
                end
                S_NEXT: begin
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
                    if (chk_q) begin
                        state_q <= S_DONE;
                    end else
`endif
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_q <= byte_idx_q + BW'(1);
                        state_q    <= S_SEND;
                    end else if (next_hit_d[CH_W]) begin
                        ch_idx_q   <= next_hit_d[CH_W-1:0];
                        byte_idx_q <= '0;
                        state_q    <= S_SEND;
                    end else begin
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
                        state_q    <= S_CHK;
`else
                        state_q    <= S_DONE;
`endif
                    end
                end
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
                S_CHK: begin
                    chk_q   <= 1'b1;
                    state_q <= S_SEND;
                end
`endif
                S_DONE: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snapshot_serializer.sv
module tb_snapshot_serializer;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*DW-1:0] can;
    logic [N-1:0]  mask;
    logic          start;
    logic          txdone;
    logic          txs;
    logic [OW-1:0] dtx;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    snapshot_serializer #(
        .CANT_CANALES(N),
        .DATA_WIDTH(DW),
        .OUTPUT_WORD_LENGTH(OW)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_canales(can),
        .i_mask(mask),
        .i_start(start),
        .i_tx_done(txdone),
        .o_tx_start(txs),
        .o_data_tx(dtx),
        .o_busy(busy),
        .o_done(done)
    );

    int checks   = 0;
    int failures = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] ch [N];
    logic [7:0]    exp_q[$];
    logic [7:0]    rx_log[$];
    int            done_expected = 0;
    int            frame_bytes   = 0;
    int unsigned   last_done_c   = 0;
    int unsigned   spur_c        = 32'hFFFF_FFFF;
    int            delay_cfg     = 5;
    bit            rand_delay    = 1'b0;

    logic [7:0] lit [16] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h14,
                             8'h00, 8'h00, 8'h00, 8'h07, 8'h8C, 8'h22, 8'h00, 8'h04};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [N*DW-1:0] pack();
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = ch[k];
        return r;
    endfunction

    // Reference frame: enabled channels ascending, each word MSB byte first.
    task automatic build_expect(input logic [N-1:0] m);
        logic [7:0] x;
        logic [7:0] cs;
        cs = 8'h00;
        for (int k = 0; k < N; k++) begin
            if (m[k]) begin
                for (int b = 0; b < DW/8; b++) begin
                    x = 8'(ch[k] >> (DW - 8*(b+1)));
                    exp_q.push_back(x);
                    cs ^= x;
                end
            end
        end
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    // tx model: answers every o_tx_start with one i_tx_done pulse after a delay;
    // also injects a spurious pulse on request.
    initial begin
        int cnt;
        cnt = 0;
        txdone = 1'b0;
        forever begin
            @(negedge clk);
            txdone = 1'b0;
            if (cyc == spur_c) txdone = 1'b1;
            if (!busy) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    txdone = 1'b1;
                    last_done_c = cyc;
                end
            end
            if (txs) cnt = rand_delay ? int'($urandom_range(1, 6)) : delay_cfg;
        end
    end

    // Compare process: every byte, every completion strobe, handshake timing.
    always @(negedge clk) begin
        int gap;
        if (txs) begin
            check("busy_with_txstart", busy, 1);
            check("bytes_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                if (frame_bytes > 0) begin
                    gap = 3;
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
                    if (exp_q.size() == 1) gap = 4;
`endif
                    check("byte_gap", cyc - last_done_c, gap);
                end
                check("data_byte", dtx, exp_q.pop_front());
                rx_log.push_back(dtx);
                frame_bytes++;
            end
        end
        if (done) begin
            check("done_busy_low", busy, 0);
            check("done_expected", done_expected > 0, 1);
            check("done_all_bytes_sent", exp_q.size(), 0);
            if (frame_bytes > 0) check("done_gap", cyc - last_done_c, 3);
            if (done_expected > 0) done_expected--;
        end
        if (!busy) frame_bytes = 0;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic run_frame(input logic [N-1:0] m, input bit toggle,
                             input bit start_in_wait, input bit spur_send);
        int budget;
        can = pack();
        mask = m;
        rx_log.delete();
        build_expect(m);
        done_expected++;
        start = 1'b1;
        if (spur_send) spur_c = cyc + 1;   // lands in SEND
        @(negedge clk); #1;
        start = 1'b0;
        if (toggle) can = {$urandom(), $urandom(), $urandom(), $urandom()};
        check("no_early_txstart", txs, 0);
        check("busy_after_capture", busy, 1);
        @(negedge clk); #1;
        if (toggle) can = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (m != '0) begin
            check("start_latency_txstart", txs, 1);
            check("start_latency_busy", busy, 1);
        end else begin
`ifndef SNAPSHOT_SERIALIZER_CHECKSUM_EN
            check("empty_mask_done", done, 1);
`endif
        end
        budget = 0;
        while (done_expected > 0 && budget < 3000) begin
            @(negedge clk); #1;
            budget++;
            if (toggle) can = {$urandom(), $urandom(), $urandom(), $urandom()};
            start = (start_in_wait && budget == 3);
        end
        start = 1'b0;
        check("frame_done_in_time", budget < 3000, 1);
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
        check("frame_byte_count", rx_log.size(), $countones(m) * (DW/8) + 1);
`else
        check("frame_byte_count", rx_log.size(), $countones(m) * (DW/8));
`endif
        idle(6);
    endtask

    initial begin
        int budget;
        rst = 1'b1; start = 1'b0; mask = '0; can = '0;
        for (int k = 0; k < N; k++) ch[k] = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_txstart", txs, 0);
        check("reset_data", dtx, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        idle(2);

        // Full frame with literal pin of the reference model
        ch[0] = 32'h0000_0010; ch[1] = 32'h0000_0014;
        ch[2] = 32'h0000_0007; ch[3] = 32'h8C22_0004;
        run_frame(4'b1111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            check("full_frame_literal", (i < rx_log.size()) ? 32'(rx_log[i]) : 32'hDEAD, lit[i]);
`ifdef SNAPSHOT_SERIALIZER_CHECKSUM_EN
        // XOR of the 16 bytes above
        check("checksum_literal", (rx_log.size() > 16) ? 32'(rx_log[16]) : 32'hDEAD, 8'hA9);
`endif

        // Sparse mask, channels toggling after capture
        for (int k = 0; k < N; k++) ch[k] = $urandom();
        run_frame(4'b1010, 1'b1, 1'b0, 1'b0);

        // Empty mask
        run_frame(4'b0000, 1'b0, 1'b0, 1'b0);

        // Ignored events: tx_done in IDLE and SEND, start during WAIT
        spur_c = cyc + 1;
        idle(1);
        for (int k = 0; k < N; k++) ch[k] = $urandom();
        run_frame(4'b1111, 1'b0, 1'b1, 1'b1);

        // Reset while waiting on byte 2
        for (int k = 0; k < N; k++) ch[k] = $urandom();
        can = pack(); mask = 4'b1111;
        rx_log.delete();
        build_expect(4'b1111);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (frame_bytes < 3 && budget < 500) begin
            @(negedge clk); #1;
            budget++;
        end
        check("reach_byte2", frame_bytes, 3);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("midreset_txstart", txs, 0);
        check("midreset_data", dtx, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        idle(12);
        for (int k = 0; k < N; k++) ch[k] = $urandom();
        run_frame(4'b1111, 1'b0, 1'b0, 1'b0);

        // Start and reset together: nothing captured
        can = {$urandom(), $urandom(), $urandom(), $urandom()};
        mask = 4'b1111; rst = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("start_reset_busy", busy, 0);
        idle(10);
        check("start_reset_still_idle", busy, 0);

        // Randomized frames
        rand_delay = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < N; k++) ch[k] = $urandom();
            run_frame(4'($urandom()), 1'($urandom()), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
